// File: rtl/alu_if.sv
// Execute-stage ALU bus: instruction and register operands in,
// registered result and flags out.
interface alu_if;
  logic [31:0] instruction;
  logic [31:0] regA;
  logic [31:0] regB;
  logic [31:0] result;
  logic [2:0]  flags;  // [2] zero, [1] negative, [0] overflow

  // Decode/issue side drives the instruction and operands.
  modport master (
    output instruction,
    output regA,
    output regB,
    input  result,
    input  flags
  );

  // ALU side consumes the instruction and returns the registered result.
  modport slave (
    input  instruction,
    input  regA,
    input  regB,
    output result,
    output flags
  );
endinterface : alu_if

// File: rtl/alu.sv
// MIPS-subset execute-stage ALU. Decode and compute are combinational.
// The result and the zero/negative/overflow flags are registered, so the
// latency is one cycle and a new instruction can issue every cycle.
module alu (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  // ---------------------------------------------------------------------
  // Encodings
  // ---------------------------------------------------------------------
  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_SRA  = 6'h03,
    FN_SLLV = 6'h04,
    FN_SRLV = 6'h06,
    FN_SRAV = 6'h07,
    FN_ADD  = 6'h20,
    FN_ADDU = 6'h21,
    FN_SUB  = 6'h22,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } func_e;

  // Operation class after decode; I-type forms map onto the same classes.
  typedef enum logic [3:0] {
    K_NONE,
    K_ADD,
    K_SUB,
    K_AND,
    K_OR,
    K_XOR,
    K_NOR,
    K_SLT,
    K_SLTU,
    K_SLL,
    K_SRL,
    K_SRA,
    K_BRANCH
  } kind_e;

  // Where the second operand comes from.
  typedef enum logic [1:0] {
    SRC_RT,
    SRC_SEXT,
    SRC_ZEXT
  } src_b_e;

  typedef struct packed {
    kind_e  kind;
    src_b_e src_b;
    logic   chk_ovf;    // report signed overflow (add/sub/addi only)
    logic   shift_var;  // shift amount from rs[4:0] instead of shamt
  } decode_t;

  // Register-index operand select: index 0/1 pick regA/regB, others read 0.
  function automatic logic [31:0] sel_reg(input logic [4:0]  idx,
                                          input logic [31:0] reg_a,
                                          input logic [31:0] reg_b);
    logic [31:0] val;
    unique case (idx)
      5'd0:    val = reg_a;
      5'd1:    val = reg_b;
      default: val = 32'h0;
    endcase
    return val;
  endfunction

  // ---------------------------------------------------------------------
  // Field extraction and operand selection
  // ---------------------------------------------------------------------
  logic [5:0]  w_opcode;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_shamt;
  logic [5:0]  w_func;
  logic [15:0] w_imm;

  assign w_opcode = bus.instruction[31:26];
  assign w_rs     = bus.instruction[25:21];
  assign w_rt     = bus.instruction[20:16];
  assign w_shamt  = bus.instruction[10:6];
  assign w_func   = bus.instruction[5:0];
  assign w_imm    = bus.instruction[15:0];

  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic [31:0] w_imm_sext;
  logic [31:0] w_imm_zext;

  assign w_rs_val   = sel_reg(w_rs, bus.regA, bus.regB);
  assign w_rt_val   = sel_reg(w_rt, bus.regA, bus.regB);
  assign w_imm_sext = {{16{w_imm[15]}}, w_imm};
  assign w_imm_zext = {16'h0, w_imm};

  // ---------------------------------------------------------------------
  // Decode: map opcode/func to an operation class and operand source
  // ---------------------------------------------------------------------
  decode_t w_dec;

  // Instruction decode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before
    // any branch, so no path leaves it unassigned and no latch is inferred.
    w_dec = '{kind: K_NONE, src_b: SRC_RT, chk_ovf: 1'b0, shift_var: 1'b0};
    unique case (w_opcode)
      OP_RTYPE: begin
        unique case (w_func)
          FN_ADD:  begin w_dec.kind = K_ADD; w_dec.chk_ovf = 1'b1; end
          FN_ADDU: w_dec.kind = K_ADD;
          FN_SUB:  begin w_dec.kind = K_SUB; w_dec.chk_ovf = 1'b1; end
          FN_SUBU: w_dec.kind = K_SUB;
          FN_AND:  w_dec.kind = K_AND;
          FN_OR:   w_dec.kind = K_OR;
          FN_XOR:  w_dec.kind = K_XOR;
          FN_NOR:  w_dec.kind = K_NOR;
          FN_SLT:  w_dec.kind = K_SLT;
          FN_SLTU: w_dec.kind = K_SLTU;
          FN_SLL:  w_dec.kind = K_SLL;
          FN_SRL:  w_dec.kind = K_SRL;
          FN_SRA:  w_dec.kind = K_SRA;
          FN_SLLV: begin w_dec.kind = K_SLL; w_dec.shift_var = 1'b1; end
          FN_SRLV: begin w_dec.kind = K_SRL; w_dec.shift_var = 1'b1; end
          FN_SRAV: begin w_dec.kind = K_SRA; w_dec.shift_var = 1'b1; end
          default: w_dec.kind = K_NONE;
        endcase
      end
      OP_ADDI: begin
        w_dec.kind    = K_ADD;
        w_dec.src_b   = SRC_SEXT;
        w_dec.chk_ovf = 1'b1;
      end
      OP_ADDIU, OP_LW, OP_SW: begin
        // Plain wrapping add; lw/sw produce the effective address.
        w_dec.kind  = K_ADD;
        w_dec.src_b = SRC_SEXT;
      end
      OP_SLTI:  begin w_dec.kind = K_SLT;  w_dec.src_b = SRC_SEXT; end
      OP_SLTIU: begin w_dec.kind = K_SLTU; w_dec.src_b = SRC_SEXT; end
      OP_ANDI:  begin w_dec.kind = K_AND;  w_dec.src_b = SRC_ZEXT; end
      OP_ORI:   begin w_dec.kind = K_OR;   w_dec.src_b = SRC_ZEXT; end
      OP_XORI:  begin w_dec.kind = K_XOR;  w_dec.src_b = SRC_ZEXT; end
      // beq and bne produce identical outputs; the branch decision is
      // taken downstream from the zero flag.
      OP_BEQ, OP_BNE: w_dec.kind = K_BRANCH;
      default: w_dec.kind = K_NONE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  logic [31:0] w_op_b;
  logic [4:0]  w_sh_amt;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic        w_add_ovf;
  logic        w_sub_ovf;
  logic        w_lt_s;
  logic        w_lt_u;

  // Second-operand mux: register rt or one of the extended immediates.
  always_comb begin
    w_op_b = w_rt_val;
    unique case (w_dec.src_b)
      SRC_SEXT: w_op_b = w_imm_sext;
      SRC_ZEXT: w_op_b = w_imm_zext;
      default:  w_op_b = w_rt_val;
    endcase
  end

  assign w_sh_amt = w_dec.shift_var ? w_rs_val[4:0] : w_shamt;
  assign w_sum    = w_rs_val + w_op_b;
  assign w_diff   = w_rs_val - w_op_b;

  // Signed overflow: operands agree in sign (add) or differ (sub) and the
  // wrapped result's sign differs from the first operand.
  assign w_add_ovf = (w_rs_val[31] == w_op_b[31]) && (w_sum[31]  != w_rs_val[31]);
  assign w_sub_ovf = (w_rs_val[31] != w_op_b[31]) && (w_diff[31] != w_rs_val[31]);

  assign w_lt_s = $signed(w_rs_val) < $signed(w_op_b);
  assign w_lt_u = w_rs_val < w_op_b;

  logic [31:0] w_next_result;
  logic [2:0]  w_next_flags;

  // Result and flag selection; only the flag owned by the operation may be set.
  always_comb begin
    w_next_result = 32'h0;
    w_next_flags  = 3'b000;
    unique case (w_dec.kind)
      K_ADD: begin
        w_next_result   = w_sum;
        w_next_flags[0] = w_dec.chk_ovf & w_add_ovf;
      end
      K_SUB: begin
        w_next_result   = w_diff;
        w_next_flags[0] = w_dec.chk_ovf & w_sub_ovf;
      end
      K_AND: w_next_result = w_rs_val & w_op_b;
      K_OR:  w_next_result = w_rs_val | w_op_b;
      K_XOR: w_next_result = w_rs_val ^ w_op_b;
      K_NOR: w_next_result = ~(w_rs_val | w_op_b);
      K_SLT: begin
        w_next_result   = {31'b0, w_lt_s};
        w_next_flags[1] = w_lt_s;
      end
      K_SLTU: begin
        w_next_result   = {31'b0, w_lt_u};
        w_next_flags[1] = w_lt_u;
      end
      K_SLL: w_next_result = w_rt_val << w_sh_amt;
      K_SRL: w_next_result = w_rt_val >> w_sh_amt;
      K_SRA: w_next_result = $unsigned($signed(w_rt_val) >>> w_sh_amt);
      K_BRANCH: begin
        w_next_result   = w_diff;
        w_next_flags[2] = (w_rs_val == w_rt_val);
      end
      default: begin
        w_next_result = 32'h0;
        w_next_flags  = 3'b000;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------
  logic [31:0] r_result;
  logic [2:0]  r_flags;

  // Capture result/flags each edge; synchronous reset wins over any instruction.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples its inputs as they were before the edge.
    if (!rst_n) begin
      r_result <= 32'h0;
      r_flags  <= 3'b000;
    end else begin
      r_result <= w_next_result;
      r_flags  <= w_next_flags;
    end
  end

  assign bus.result = r_result;
  assign bus.flags  = r_flags;

endmodule : alu

// File: tb/tb_alu.sv
// Self-checking bench for the alu: directed vector table, reset and
// pipelining sequences, then randomized instructions against a
// behavioural reference model.
module tb_alu;

  logic clk;
  logic rst_n;

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [63:0] name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic [2:0]  exp_flags;
  } vec_t;

  task automatic check(input logic [63:0] name,
                       input logic [31:0] got_r, input logic [2:0] got_f,
                       input logic [31:0] exp_r, input logic [2:0] exp_f);
    n_checks++;
    if (got_r === exp_r && got_f === exp_f) n_pass++;
    else $display("FAIL %s: result=%h flags=%b, expected result=%h flags=%b",
                  name, got_r, got_f, exp_r, exp_f);
  endtask

  // Present one instruction away from the edge, then step past the edge.
  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.instruction = ins;
    bus.regA        = a;
    bus.regB        = b;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] pick(input logic [4:0] idx, input logic [31:0] a, input logic [31:0] b);
    if (idx == 5'd0) return a;
    if (idx == 5'd1) return b;
    return 32'h0;
  endfunction

  function automatic logic out_of_range(input longint v);
    return (v > 64'sd2147483647) || (v < -64'sd2147483648);
  endfunction

  function automatic void ref_alu(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic [2:0] fl);
    logic [31:0] s, t, se, ze;
    logic [4:0]  sh;
    longint      sl, tl, sel;
    s   = pick(ins[25:21], a, b);
    t   = pick(ins[20:16], a, b);
    se  = {{16{ins[15]}}, ins[15:0]};
    ze  = {16'h0, ins[15:0]};
    sh  = ins[10:6];
    sl  = longint'($signed(s));
    tl  = longint'($signed(t));
    sel = longint'($signed(se));
    res = 32'h0;
    fl  = 3'b000;
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: begin res = s + t; fl[0] = out_of_range(sl + tl); end
        6'h21: res = s + t;
        6'h22: begin res = s - t; fl[0] = out_of_range(sl - tl); end
        6'h23: res = s - t;
        6'h24: res = s & t;
        6'h25: res = s | t;
        6'h26: res = s ^ t;
        6'h27: res = ~(s | t);
        6'h2A: begin res = (sl < tl) ? 32'd1 : 32'd0; fl[1] = res[0]; end
        6'h2B: begin res = (s < t) ? 32'd1 : 32'd0; fl[1] = res[0]; end
        6'h00: res = t << sh;
        6'h02: res = t >> sh;
        6'h03: res = $signed(t) >>> sh;
        6'h04: res = t << s[4:0];
        6'h06: res = t >> s[4:0];
        6'h07: res = $signed(t) >>> s[4:0];
        default: ;
      endcase
      6'h08: begin res = s + se; fl[0] = out_of_range(sl + sel); end
      6'h09, 6'h23, 6'h2B: res = s + se;
      6'h0A: begin res = (sl < sel) ? 32'd1 : 32'd0; fl[1] = res[0]; end
      6'h0B: begin res = (s < se) ? 32'd1 : 32'd0; fl[1] = res[0]; end
      6'h0C: res = s & ze;
      6'h0D: res = s | ze;
      6'h0E: res = s ^ ze;
      6'h04, 6'h05: begin res = s - t; fl[2] = (s == t); end
      default: ;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  vec_t vecs[23];
  logic [5:0]  ops[14]   = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                             6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h3F, 6'h01};
  logic [5:0]  funcs[18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                             6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h01, 6'h3F};
  logic [31:0] corner[6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'h80000001, 32'hFFFFFFFF};

  function automatic logic [31:0] rand_data();
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    logic [31:0] er, ins, a, b;
    logic [2:0]  ef;

    vecs[0]  = '{"add_ov",  32'h00201820, 32'h80000001, 32'h80000001, 32'h00000002, 3'b001};
    vecs[1]  = '{"addu",    32'h00201821, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 3'b000};
    vecs[2]  = '{"sub_ov",  32'h00011822, 32'h6DDDDDDD, 32'h80000001, 32'hEDDDDDDC, 3'b001};
    vecs[3]  = '{"andi",    32'h30008000, 32'hFFFF80DD, 32'h00000000, 32'h00008000, 3'b000};
    vecs[4]  = '{"xori",    32'h3801800F, 32'h00008000, 32'h00000000, 32'h0000000F, 3'b000};
    vecs[5]  = '{"addiu",   32'h2420FFFF, 32'h00000000, 32'h00000001, 32'h00000000, 3'b000};
    vecs[6]  = '{"lw",      32'h8C019998, 32'h00000001, 32'h00000000, 32'hFFFF9999, 3'b000};
    vecs[7]  = '{"sll",     32'h00001200, 32'h00000100, 32'h00000000, 32'h00010000, 3'b000};
    vecs[8]  = '{"sra",     32'h000110C3, 32'h00000000, 32'h80000000, 32'hF0000000, 3'b000};
    vecs[9]  = '{"srav",    32'h00011007, 32'hDDDDDDC7, 32'h8000007F, 32'hFF000000, 3'b000};
    vecs[10] = '{"slt",     32'h0020182A, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 3'b010};
    vecs[11] = '{"sltiu",   32'h2C20982B, 32'h00000000, 32'h80000001, 32'h00000001, 3'b010};
    vecs[12] = '{"beq",     32'h1020182B, 32'h12345678, 32'h12345678, 32'h00000000, 3'b100};
    vecs[13] = '{"bne",     32'h1420182B, 32'h6DDDDDDD, 32'h6DDDDDDC, 32'hFFFFFFFF, 3'b000};
    vecs[14] = '{"addi_ov", 32'h20007FFF, 32'h7FFFFFFF, 32'h00000000, 32'h80007FFE, 3'b001};
    vecs[15] = '{"slti",    32'h2800FFFF, 32'h80000000, 32'h00000000, 32'h00000001, 3'b010};
    vecs[16] = '{"sltu",    32'h0020182B, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 3'b000};
    vecs[17] = '{"nor",     32'h00011827, 32'hF0F0F0F0, 32'h0000FFFF, 32'h0F0F0000, 3'b000};
    vecs[18] = '{"add_r23", 32'h00431820, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 3'b000};
    vecs[19] = '{"beq_r57", 32'h10A70000, 32'h00000005, 32'h00000007, 32'h00000000, 3'b100};
    vecs[20] = '{"bad_fn",  32'h00011801, 32'h00000005, 32'h00000007, 32'h00000000, 3'b000};
    vecs[21] = '{"bad_op",  32'hFC011820, 32'h00000005, 32'h00000007, 32'h00000000, 3'b000};
    vecs[22] = '{"sw",      32'hAC010004, 32'h00000100, 32'h00000000, 32'h00000104, 3'b000};

    // Reset state, with an overflowing add presented the whole time.
    rst_n           = 1'b0;
    bus.instruction = 32'h00201820;
    bus.regA        = 32'h80000001;
    bus.regB        = 32'h80000001;
    repeat (3) @(posedge clk);
    #1;
    check("reset", bus.result, bus.flags, 32'h0, 3'b000);

    // First edge after release shows the current instruction.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_1st", bus.result, bus.flags, 32'h00000002, 3'b001);

    // Reset asserted for one edge mid-stream, then released.
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_pri", bus.result, bus.flags, 32'h0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rel", bus.result, bus.flags, 32'h00000002, 3'b001);

    // Directed vector table, one instruction per cycle.
    foreach (vecs[i]) begin
      issue(vecs[i].instr, vecs[i].a, vecs[i].b);
      check(vecs[i].name, bus.result, bus.flags, vecs[i].exp_res, vecs[i].exp_flags);
    end

    // Output holds while inputs are unchanged, then follows a new input
    // on the very next edge (flags cleared when the new op owns none).
    issue(32'h00201820, 32'h80000001, 32'h80000001);
    @(posedge clk);
    #1;
    check("hold", bus.result, bus.flags, 32'h00000002, 3'b001);
    issue(32'h00201821, 32'h80000001, 32'h80000001);
    check("b2b", bus.result, bus.flags, 32'h00000002, 3'b000);

    // Randomized instructions against the reference model.
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 13)];
      if (ins[31:26] == 6'h00) ins[5:0] = funcs[$urandom_range(0, 17)];
      if ($urandom_range(0, 7) != 0) begin
        ins[25:21] = 5'($urandom_range(0, 2));
        ins[20:16] = 5'($urandom_range(0, 2));
      end
      a = rand_data();
      b = rand_data();
      if ($urandom_range(0, 9) == 0) b = a;
      ref_alu(ins, a, b, er, ef);
      issue(ins, a, b);
      check("rand", bus.result, bus.flags, er, ef);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_alu

// File: doc/alu.md
# alu

Single-cycle-issue MIPS-subset arithmetic/logic unit with a registered result, used as the execute-stage datapath element. It decodes a 32-bit MIPS instruction, selects operands from two presented register values, and produces a 32-bit result plus zero/negative/overflow flags. Outputs are registered one clock after the inputs are sampled.

## Interface
- No parameters; data width is fixed at 32 bits.
- `clk`  input  1  rising-edge clock. One clock domain; reset is synchronous and active-low.
- `rst_n`  input  1  synchronous active-low reset.
- `instruction`  input  32  MIPS instruction.
- `regA`  input  32  value of register index 0.
- `regB`  input  32  value of register index 1.
- `result`  output  32  registered ALU result.
- `flags`  output  3  registered flags:
  - `[2]` zero
  - `[1]` negative
  - `[0]` overflow

## Operation
- Decode fields:
  - opcode = instr[31:26]
  - rs = [25:21]
  - rt = [20:16]
  - shamt = [10:6]
  - func = [5:0]
  - imm = [15:0]
- Operand selection applies separately to rs and rt: field 0 → regA; field 1 → regB; any other value → 32'h0.
- Immediates:
  - sign-extended for addi, addiu, slti, sltiu, lw, sw.
  - zero-extended for andi, ori, xori.
- R-type (opcode 0x00), selected by func:
  - 0x20 add: rs+rt; overflow flag on signed overflow.
  - 0x21 addu: rs+rt; no flags.
  - 0x22 sub: rs−rt; overflow flag on signed overflow.
  - 0x23 subu: rs−rt; no flags.
  - 0x24 and, 0x25 or, 0x26 xor, 0x27 nor: bitwise on rs, rt.
  - 0x2A slt: result = {31'b0, lt}, where lt = signed rs<rt; negative flag = lt.
  - 0x2B sltu: same as slt, but unsigned compare.
  - 0x00 sll, 0x02 srl, 0x03 sra: shift rt by shamt (sra is arithmetic).
  - 0x04 sllv, 0x06 srlv, 0x07 srav: shift rt by rs[4:0].
- I-type, selected by opcode:
  - 0x08 addi: rs+imm; overflow flag on signed overflow.
  - 0x09 addiu: rs+imm; no flags.
  - 0x0C andi, 0x0D ori, 0x0E xori: bitwise on rs and zero-extended imm.
  - 0x0A slti, 0x0B sltiu: result = {31'b0, lt}; negative flag = lt (signed / unsigned compare against the sign-extended imm).
  - 0x04 beq, 0x05 bne: result = rs−rt; zero flag = (rs==rt), identical for both opcodes.
  - 0x23 lw, 0x2B sw: result = rs+imm (address); no flags.
- Flags:
  - Only the flag named for an operation may be set; all other flag bits are 0.
  - Add/sub results wrap modulo 2^32 even when overflow is flagged.
- Unsupported opcode or func: result 32'h0, flags 3'b000.

## Timing
- All decode and compute logic is combinational.
- result and flags are captured on the rising edge of clk: latency is 1 cycle, throughput is one instruction per cycle.
- No handshake. Inputs are sampled every edge; outputs hold until the next edge.
- Reset: when rst_n=0 at a rising edge, result ← 32'h0 and flags ← 3'b000, regardless of inputs. Reset has priority over any instruction in flight.
- First valid output appears on the first edge after rst_n returns to 1.

## Test plan
- **add / addu / sub:**
  - add (0x00201820), regA=regB=0x80000001 → result 0x00000002, flags 001.
  - addu (0x00201821), regA=0xFFFFFFFF, regB=1 → result 0, flags 000.
  - sub (0x00011822), regA=0x6DDDDDDD, regB=0x80000001 → result 0xEDDDDDDC, flags 001.
- **Immediates and address generation:**
  - andi 0x30008000, regA=0xFFFF80DD → 0x00008000.
  - xori 0x3801800F, regA=0x8000 → 0x0000000F.
  - addiu 0x2420FFFF, regB=1 → 0.
  - lw 0x8C019998, regA=1 → 0xFFFF9999.
- **Shifts:**
  - sll 0x00001200, regA=0x100 → 0x00010000.
  - sra 0x000110C3, regB=0x80000000 → 0xF0000000.
  - srav 0x00011007, regA=0xDDDDDDC7, regB=0x8000007F → 0xFF000000.
- **Compares:**
  - slt 0x0020182A, regA=1, regB=0xFFFFFFFF → result 1, flags 010.
  - sltiu 0x2C20982B, regB=0x80000001 → result 1, flags 010.
- **Branches:**
  - beq 0x1020182B with regA==regB → flags 100.
  - bne 0x1420182B, regA=0x6DDDDDDD, regB=0x6DDDDDDC → flags 000.
- **Reset:**
  - Drive add overflow, then hold rst_n=0 for one edge → result 0, flags 000 on that edge.
  - After release, the next edge shows the current instruction's result.
